// File: rtl/ssd1306_i2c_target.sv
// Write-only I2C target modelling the SSD1306 end of the OLED link: address, control byte, payload strobes.
// Optional build macro SSD1306_I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module ssd1306_i2c_target #(
  parameter logic [6:0] ADDR = 7'h3C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       byte_is_data,
  output logic [9:0] byte_count,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_CTRL, ST_CTRL_ACK, ST_DATA, ST_DATA_ACK, ST_IGNORE
  } state_t;

  // Handshake: byte_valid is a single-cycle strobe with no backpressure;
  // byte_out/byte_is_data/byte_count are valid in the strobe cycle and hold afterwards.
  state_t     state;
  logic       scl_meta, scl_sync, sda_meta, sda_sync;
  logic       scl_f, sda_f, scl_q, sda_q;
  logic       sda_drive;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic       co, dc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      scl_meta <= scl;
      scl_sync <= scl_meta;
      sda_meta <= sda;
      sda_sync <= sda_meta;
    end
  end

`ifdef SSD1306_I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync};
      sda_hist <= {sda_hist[0], sda_sync};
    end
  end

  // A level must be seen on two of the last three samples, so 1-clk pulses never pass.
  assign scl_f = (scl_sync & scl_hist[0]) | (scl_sync & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
  assign sda_f = (sda_sync & sda_hist[0]) | (sda_sync & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
`else
  assign scl_f = scl_sync;
  assign sda_f = sda_sync;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det, byte_done;
  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & sda_q & ~sda_f;
  assign stop_det  = scl_f & ~sda_q & sda_f;
  assign byte_done = scl_fall && (bit_cnt == 4'd8);

  assign sda = sda_drive ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sda_drive    <= 1'b0;
      bit_cnt      <= 4'd0;
      shift        <= 8'h00;
      co           <= 1'b0;
      dc           <= 1'b0;
      byte_out     <= 8'h00;
      byte_valid   <= 1'b0;
      byte_is_data <= 1'b0;
      byte_count   <= 10'd0;
      busy         <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      // Bus conditions win over any SCL edge seen in the same cycle.
      if (start_det) begin
        state      <= ST_ADDR;
        sda_drive  <= 1'b0;
        byte_count <= 10'd0;
        bit_cnt    <= 4'd0;
        shift      <= 8'h00;
      end else if (stop_det) begin
        state     <= ST_IDLE;
        sda_drive <= 1'b0;
        busy      <= 1'b0;
      end else begin
        if ((state == ST_ADDR || state == ST_CTRL || state == ST_DATA) &&
            scl_rise && bit_cnt != 4'd8) begin
          shift   <= {shift[6:0], sda_f};
          bit_cnt <= bit_cnt + 4'd1;
        end
        case (state)
          ST_IDLE: begin
          end
          ST_ADDR: begin
            if (byte_done) begin
              bit_cnt <= 4'd0;
              if (shift[7:1] == ADDR && !shift[0]) begin
                state     <= ST_ADDR_ACK;
                sda_drive <= 1'b1;
                busy      <= 1'b1;
              end else begin
                state <= ST_IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          ST_CTRL: begin
            if (byte_done) begin
              bit_cnt   <= 4'd0;
              co        <= shift[7];
              dc        <= shift[6];
              state     <= ST_CTRL_ACK;
              sda_drive <= 1'b1;
            end
          end
          ST_DATA: begin
            if (byte_done) begin
              bit_cnt      <= 4'd0;
              byte_out     <= shift;
              byte_valid   <= 1'b1;
              byte_is_data <= dc;
              if (byte_count != 10'h3FF) byte_count <= byte_count + 10'd1;
              state        <= ST_DATA_ACK;
              sda_drive    <= 1'b1;
            end
          end
          ST_ADDR_ACK, ST_CTRL_ACK: begin
            if (scl_fall) begin
              sda_drive <= 1'b0;
              state     <= (state == ST_ADDR_ACK) ? ST_CTRL : ST_DATA;
            end
          end
          ST_DATA_ACK: begin
            if (scl_fall) begin
              sda_drive <= 1'b0;
              state     <= co ? ST_CTRL : ST_DATA;
            end
          end
          ST_IGNORE: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssd1306_i2c_target.sv
// Directed bench for ssd1306_i2c_target: bit-banged I2C master, strobe scoreboard, summary line.
module tb_ssd1306_i2c_target;

  logic       clk;
  logic       rst_n;
  logic       scl;
  logic       sda_low;
  wire        sda;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_is_data;
  logic [9:0] byte_count;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int q     = 4;
  logic [8:0] exp_q[$];
  logic       bv_prev = 1'b0;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  ssd1306_i2c_target #(.ADDR(7'h3C)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_is_data(byte_is_data),
    .byte_count(byte_count), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: each strobe must match the head of exp_q and last one clk
  always @(negedge clk) begin
    if (rst_n && byte_valid) begin
      total++;
      if (bv_prev !== 1'b0) begin
        bad++;
        $display("FAIL byte_valid_width got=2+clk want=1clk");
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe got=%0h/%0b want=none", byte_out, byte_is_data);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({byte_is_data, byte_out} !== e) begin
          bad++;
          $display("FAIL strobe got=%0b/%02h want=%0b/%02h", byte_is_data, byte_out, e[8], e[7:0]);
        end
      end
    end
    bv_prev = rst_n ? byte_valid : 1'b0;
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_low = 1'b0; wait_clk(q);
    scl = 1'b1;     wait_clk(q);
    sda_low = 1'b1; wait_clk(q);
    scl = 1'b0;     wait_clk(q);
  endtask

  task automatic bus_stop();
    sda_low = 1'b1; wait_clk(q);
    scl = 1'b1;     wait_clk(q);
    sda_low = 1'b0; wait_clk(2 * q);
  endtask

  task automatic write_bit(input logic b);
    sda_low = ~b; wait_clk(q);
    scl = 1'b1;   wait_clk(2 * q);
    scl = 1'b0;   wait_clk(q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_low = 1'b0; wait_clk(q);
    scl = 1'b1;     wait_clk(q);
    ack = (sda === 1'b0);
    wait_clk(q);
    scl = 1'b0;     wait_clk(q);
  endtask

  task automatic test_reset();
    total++;
    if ({byte_out, byte_valid, byte_is_data, byte_count, busy} !== 21'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h want=0", {byte_out, byte_valid, byte_is_data, byte_count, busy});
    end
    total++;
    if (sda !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b want=1", sda); end
  endtask

  task automatic test_cmd_stream();
    logic ack;
    logic [7:0] seq[5];
    seq = '{8'h78, 8'h00, 8'hAE, 8'hD5, 8'h80};
    exp_q.push_back({1'b0, 8'hAE});
    exp_q.push_back({1'b0, 8'hD5});
    exp_q.push_back({1'b0, 8'h80});
    bus_start();
    for (int i = 0; i < 5; i++) begin
      write_byte(seq[i], ack);
      total++;
      if (ack !== 1'b1) begin bad++; $display("FAIL cmd_ack[%0d] got=%b want=1", i, ack); end
      if (i == 0) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL cmd_busy got=%b want=1", busy); end
      end
    end
    bus_stop();
    total++;
    if (byte_count !== 10'd3) begin bad++; $display("FAIL cmd_count got=%0d want=3", byte_count); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL cmd_busy_stop got=%b want=0", busy); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL cmd_missing got=%0d want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_ctrl_switch();
    logic ack;
    logic [7:0] seq[6];
    seq = '{8'h78, 8'h80, 8'hAF, 8'h40, 8'h55, 8'hAA};
    exp_q.push_back({1'b0, 8'hAF});
    exp_q.push_back({1'b1, 8'h55});
    exp_q.push_back({1'b1, 8'hAA});
    bus_start();
    for (int i = 0; i < 6; i++) begin
      write_byte(seq[i], ack);
      total++;
      if (ack !== 1'b1) begin bad++; $display("FAIL ctrl_ack[%0d] got=%b want=1", i, ack); end
    end
    bus_stop();
    total++;
    if (byte_count !== 10'd3) begin bad++; $display("FAIL ctrl_count got=%0d want=3", byte_count); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL ctrl_missing got=%0d want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_nack(input logic [7:0] addr_byte, input string tag);
    logic ack;
    bus_start();
    write_byte(addr_byte, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL %s_addr_ack got=%b want=0", tag, ack); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy got=%b want=0", tag, busy); end
    for (int i = 0; i < 2; i++) begin
      write_byte(8'h11 + 8'(i), ack);
      total++;
      if (ack !== 1'b0) begin bad++; $display("FAIL %s_data_ack[%0d] got=%b want=0", tag, i, ack); end
    end
    bus_stop();
    total++;
    if (byte_count !== 10'd0) begin bad++; $display("FAIL %s_count got=%0d want=0", tag, byte_count); end
  endtask

  task automatic test_restart();
    logic ack;
    logic [7:0] seq[3];
    seq = '{8'h78, 8'h40, 8'h12};
    bus_start();
    write_byte(8'h78, ack);
    write_byte(8'h40, ack);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    exp_q.push_back({1'b1, 8'h12});
    bus_start();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy got=%b want=1", busy); end
    total++;
    if (byte_count !== 10'd0) begin bad++; $display("FAIL restart_count_clr got=%0d want=0", byte_count); end
    for (int i = 0; i < 3; i++) begin
      write_byte(seq[i], ack);
      total++;
      if (ack !== 1'b1) begin bad++; $display("FAIL restart_ack[%0d] got=%b want=1", i, ack); end
    end
    bus_stop();
    total++;
    if (byte_count !== 10'd1) begin bad++; $display("FAIL restart_count got=%0d want=1", byte_count); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL restart_missing got=%0d want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_glitch();
    logic [9:0] want;
`ifdef SSD1306_I2C_TARGET_GLITCH_FILTER_EN
    want = 10'd1;
`else
    want = 10'd0;
`endif
    @(negedge clk) sda_low = 1'b1;
    @(negedge clk) sda_low = 1'b0;
    wait_clk(10);
    total++;
    if (byte_count !== want) begin bad++; $display("FAIL glitch_count got=%0d want=%0d", byte_count, want); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_ack();
    logic ack;
    logic [7:0] b;
    b = 8'hAE;
    exp_q.push_back({1'b0, 8'hAE});
    bus_start();
    write_byte(8'h78, ack);
    write_byte(8'h00, ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_low = 1'b0; wait_clk(q);
    scl = 1'b1;     wait_clk(q);
    total++;
    if (sda !== 1'b0) begin bad++; $display("FAIL mid_ack_drive got=%b want=0", sda); end
    @(negedge clk) rst_n = 1'b0;
    #1;
    total++;
    if (sda !== 1'b1) begin bad++; $display("FAIL mid_rst_sda got=%b want=1", sda); end
    total++;
    if ({byte_out, byte_valid, byte_is_data, byte_count, busy} !== 21'd0) begin
      bad++;
      $display("FAIL mid_rst_outputs got=%0h want=0", {byte_out, byte_valid, byte_is_data, byte_count, busy});
    end
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(2 * q);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL mid_missing got=%0d want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_saturation();
    logic ack;
    int nacks;
    nacks = 0;
    q = 2;
    for (int i = 0; i < 1025; i++) exp_q.push_back({1'b1, 8'(i)});
    bus_start();
    write_byte(8'h78, ack);
    if (!ack) nacks++;
    write_byte(8'h40, ack);
    if (!ack) nacks++;
    for (int i = 0; i < 1025; i++) begin
      write_byte(8'(i), ack);
      if (!ack) nacks++;
    end
    bus_stop();
    q = 4;
    total++;
    if (nacks != 0) begin bad++; $display("FAIL sat_acks got=%0d nacks want=0", nacks); end
    total++;
    if (byte_count !== 10'd1023) begin bad++; $display("FAIL sat_count got=%0d want=1023", byte_count); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sat_missing got=%0d want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    scl = 1'b1;
    sda_low = 1'b0;
    wait_clk(5);
    test_reset();
    rst_n = 1'b1;
    wait_clk(5);
    test_cmd_stream();
    test_ctrl_switch();
    test_nack(8'h7A, "wrong_addr");
    test_nack(8'h79, "read");
    test_restart();
    test_glitch();
    test_reset_mid_ack();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
